// File: rtl/kmi_transmit.sv
// kmi_transmit: host-to-device KMI (PS/2-style) serial transmitter.
// Sends an 11-bit frame {stop, odd parity, data[7:0], start}, bit 0 first.
// Each bit advances on a falling edge of the slow device clock clk_in.
// clk_in is resynchronised into ref_clk before edge detection.
// Optional feature macro: KMI_TX_TIMEOUT_EN enables a watchdog that aborts
// a stalled frame after TIMEOUT_CYCLES ref_clk cycles with no clk_in fall.
module kmi_transmit #(
   parameter int SYNC_STAGES    = 2       // minimum 2
`ifdef KMI_TX_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 65536
`endif
) (
   input  logic       ref_clk,
   input  logic       nreset,
   input  logic       transmit,
   input  logic       clk_in,
   input  logic [7:0] data_in,
   output logic       serial_out,
   output logic       ndata_en,
   output logic       tx_done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~(^d);
   endfunction

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;
   logic                   fall_s;
   logic [1:0]             state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [10:0]            shift_q, shift_d;
   logic                   serial_out_q, serial_out_d;
   logic                   ndata_en_q, ndata_en_d;
   logic                   tx_done_q, tx_done_d;

`ifdef KMI_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_q, wd_d;
`endif

   // Synchroniser shift (stage 0 samples the pin) and one-cycle history for edge detect.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], clk_in};
      hist_d = sync_q[SYNC_STAGES-1];
      fall_s = hist_q & ~sync_q[SYNC_STAGES-1];
   end

   // Frame sequencing: accept in IDLE, shift one bit per clk_in fall, pulse done.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      serial_out_d = serial_out_q;
      ndata_en_d   = ndata_en_q;
      tx_done_d    = 1'b0;
`ifdef KMI_TX_TIMEOUT_EN
      wd_d         = {WD_W{1'b0}};
`endif
      case (state_q)
         ST_IDLE: begin
            if (transmit) begin
               shift_d      = {1'b1, odd_parity(data_in), data_in, 1'b0};
               serial_out_d = 1'b0;
               ndata_en_d   = 1'b0;
               cnt_d        = 4'd0;
               state_d      = ST_SEND;
            end else begin
               serial_out_d = 1'b1;
               ndata_en_d   = 1'b1;
            end
         end
         ST_SEND: begin
            if (fall_s) begin
               if (cnt_q == 4'd10) begin
                  // Stop bit has been clocked out: release the line.
                  serial_out_d = 1'b1;
                  ndata_en_d   = 1'b1;
                  tx_done_d    = 1'b1;
                  cnt_d        = 4'd0;
                  state_d      = ST_DONE;
               end else begin
                  cnt_d        = cnt_q + 4'd1;
                  shift_d      = {1'b0, shift_q[10:1]};
                  serial_out_d = shift_q[1];
               end
            end else begin
`ifdef KMI_TX_TIMEOUT_EN
               if (wd_q == WD_LAST) begin
                  // Device stopped clocking: abandon the frame silently.
                  serial_out_d = 1'b1;
                  ndata_en_d   = 1'b1;
                  cnt_d        = 4'd0;
                  state_d      = ST_IDLE;
               end else begin
                  wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
               end
`else
               serial_out_d = serial_out_q;
`endif
            end
         end
         ST_DONE: begin
            serial_out_d = 1'b1;
            ndata_en_d   = 1'b1;
            state_d      = ST_IDLE;
         end
         default: begin
            serial_out_d = 1'b1;
            ndata_en_d   = 1'b1;
            cnt_d        = 4'd0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge ref_clk) begin
      if (!nreset) begin
         sync_q       <= {SYNC_STAGES{1'b1}};
         hist_q       <= 1'b1;
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         shift_q      <= 11'd0;
         serial_out_q <= 1'b1;
         ndata_en_q   <= 1'b1;
         tx_done_q    <= 1'b0;
`ifdef KMI_TX_TIMEOUT_EN
         wd_q         <= {WD_W{1'b0}};
`endif
      end else begin
         sync_q       <= sync_d;
         hist_q       <= hist_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         serial_out_q <= serial_out_d;
         ndata_en_q   <= ndata_en_d;
         tx_done_q    <= tx_done_d;
`ifdef KMI_TX_TIMEOUT_EN
         wd_q         <= wd_d;
`endif
      end
   end

   assign serial_out = serial_out_q;
   assign ndata_en   = ndata_en_q;
   assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_kmi_transmit.sv
// tb_kmi_transmit: directed self-checking bench for kmi_transmit.
// clk_in is driven by the bench one edge at a time so each bit can be
// checked just before and just after the fall is taken.
`timescale 1ns/100ps
module tb_kmi_transmit;

   logic       ref_clk = 1'b0;
   logic       nreset;
   logic       transmit;
   logic       clk_in;
   logic [7:0] data_in;
   logic       serial_out;
   logic       ndata_en;
   logic       tx_done;

   int n_total = 0;
   int n_bad   = 0;
   int n_done  = 0;
   int n_wide  = 0;
   logic done_prev = 1'b0;

   kmi_transmit dut (
      .ref_clk    (ref_clk),
      .nreset     (nreset),
      .transmit   (transmit),
      .clk_in     (clk_in),
      .data_in    (data_in),
      .serial_out (serial_out),
      .ndata_en   (ndata_en),
      .tx_done    (tx_done)
   );

   // 2 ns reference clock.
   always #1 ref_clk = ~ref_clk;

   // Count done pulses and flag any pulse wider than one cycle.
   always @(posedge ref_clk) begin
      if (tx_done === 1'b1) n_done <= n_done + 1;
      if (tx_done === 1'b1 && done_prev === 1'b1) n_wide <= n_wide + 1;
      done_prev <= tx_done;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Send one frame; optionally poke transmit during SEND or DONE; stop after n_falls.
   task automatic send_frame(input logic [10:0] exp_f, input logic [7:0] d,
                             input bit inj_send, input bit inj_done, input int n_falls);
      int done0;
      done0 = n_done;
      @(negedge ref_clk);
      data_in  = d;
      transmit = 1'b1;
      @(negedge ref_clk);
      transmit = 1'b0;
      data_in  = ~d;
      chk("start_bit", {31'd0, serial_out}, {31'd0, exp_f[0]});
      chk("start_oe", {31'd0, ndata_en}, 32'd0);
      for (int i = 1; i <= n_falls; i++) begin
         repeat (12) @(negedge ref_clk);
         clk_in = 1'b0;
         @(negedge ref_clk);
         @(negedge ref_clk);
         chk("bit_hold", {31'd0, serial_out}, {31'd0, exp_f[i-1]});
         chk("done_early", {31'd0, tx_done}, 32'd0);
         @(negedge ref_clk);
         if (i <= 10) begin
            chk("bit_new", {31'd0, serial_out}, {31'd0, exp_f[i]});
            chk("oe_frame", {31'd0, ndata_en}, 32'd0);
         end else begin
            chk("stop_rel_line", {31'd0, serial_out}, 32'd1);
            chk("stop_rel_oe", {31'd0, ndata_en}, 32'd1);
            chk("done_pulse", {31'd0, tx_done}, 32'd1);
            if (inj_done) transmit = 1'b1;
         end
         @(negedge ref_clk);
         if (i == 11) chk("done_end", {31'd0, tx_done}, 32'd0);
         transmit = (inj_send && i == 4);
         if (inj_send && i == 4) data_in = 8'h55;
         @(negedge ref_clk);
         transmit = 1'b0;
         repeat (12) @(negedge ref_clk);
         clk_in = 1'b1;
      end
      if (n_falls == 11) begin
         repeat (4) @(negedge ref_clk);
         chk("idle_line", {31'd0, serial_out}, 32'd1);
         chk("idle_oe", {31'd0, ndata_en}, 32'd1);
         chk("done_count", n_done - done0, 32'd1);
         chk("done_width", n_wide, 32'd0);
      end
   endtask

   initial begin
      int done_snap;
      nreset   = 1'b0;
      transmit = 1'b0;
      clk_in   = 1'b1;
      data_in  = 8'h00;
      @(negedge ref_clk);
      chk("rst_line", {31'd0, serial_out}, 32'd1);
      chk("rst_oe", {31'd0, ndata_en}, 32'd1);
      chk("rst_done", {31'd0, tx_done}, 32'd0);
      nreset = 1'b1;
      repeat (4) @(negedge ref_clk);

      // B3: line 0 1 1 0 0 1 1 0 1 0 1
      send_frame(11'b1_0_10110011_0, 8'hB3, 1'b0, 1'b0, 11);
      // back-to-back, identical frame
      send_frame(11'b1_0_10110011_0, 8'hB3, 1'b0, 1'b0, 11);
      // parity corners
      send_frame(11'b1_1_00000000_0, 8'h00, 1'b0, 1'b0, 11);
      send_frame(11'b1_1_11111111_0, 8'hFF, 1'b0, 1'b0, 11);
      send_frame(11'b1_0_00000001_0, 8'h01, 1'b0, 1'b0, 11);
      // transmit with 55 during SEND ignored
      send_frame(11'b1_0_10110011_0, 8'hB3, 1'b1, 1'b0, 11);
      // transmit during DONE ignored
      send_frame(11'b1_1_00001111_0, 8'h0F, 1'b0, 1'b1, 11);

      // reset after 4 falls aborts the frame
      send_frame(11'b1_0_10110011_0, 8'hB3, 1'b0, 1'b0, 4);
      done_snap = n_done;
      chk("mid_oe_before_rst", {31'd0, ndata_en}, 32'd0);
      nreset = 1'b0;
      @(negedge ref_clk);
      nreset = 1'b1;
      chk("abort_line", {31'd0, serial_out}, 32'd1);
      chk("abort_oe", {31'd0, ndata_en}, 32'd1);
      chk("abort_done", {31'd0, tx_done}, 32'd0);
      for (int k = 0; k < 8; k++) begin
         repeat (12) @(negedge ref_clk);
         clk_in = 1'b0;
         repeat (12) @(negedge ref_clk);
         clk_in = 1'b1;
      end
      repeat (4) @(negedge ref_clk);
      chk("abort_stay_oe", {31'd0, ndata_en}, 32'd1);
      chk("abort_no_done", n_done - done_snap, 32'd0);

`ifdef KMI_TX_TIMEOUT_EN
      // clk_in stalls after 3 falls: watchdog releases the line without done
      send_frame(11'b1_0_10110011_0, 8'hB3, 1'b0, 1'b0, 3);
      done_snap = n_done;
      repeat (65536 - 40) @(negedge ref_clk);
      chk("wd_still_driving", {31'd0, ndata_en}, 32'd0);
      repeat (80) @(negedge ref_clk);
      chk("wd_release_oe", {31'd0, ndata_en}, 32'd1);
      chk("wd_release_line", {31'd0, serial_out}, 32'd1);
      chk("wd_no_done", n_done - done_snap, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
